// File: rtl/kbd_pkg.sv
// Shared definitions for the PDP-8 console keyboard controller (KL8E-style).
// Optional KIE support is enabled with the KBD_INT_EN macro.
package kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RESP = 2'd2
    } kbd_state_e;

    localparam int unsigned OP_SKIP_BIT  = 0;
    localparam int unsigned OP_CLEAR_BIT = 1;
    localparam int unsigned OP_READ_BIT  = 2;

    localparam logic [2:0] OP_KCF = 3'o0;
    localparam logic [2:0] OP_KSF = 3'o1;
    localparam logic [2:0] OP_KCC = 3'o2;
    localparam logic [2:0] OP_KRS = 3'o4;
    localparam logic [2:0] OP_KIE = 3'o5;
    localparam logic [2:0] OP_KRB = 3'o6;

    localparam logic [5:0] KBD_DEV_CODE = 6'o03;

endpackage

// File: rtl/kbd_rx_ctrl_sync_fifo.sv
// Generic synchronous FIFO with show-ahead head output; a pop and a push in
// the same cycle are both honoured even when the FIFO is full.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_rd;
    logic             do_wr;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/kbd_rx_ctrl.sv
// KL8E-style keyboard controller: FIFO-buffered receive path, keyboard flag
// and IOT decode. Define KBD_INT_EN to add the KIE interrupt-enable register.
module kbd_rx_ctrl
    import kbd_pkg::*;
#(
    parameter logic [5:0]  DEV_CODE   = KBD_DEV_CODE,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_Byte,
    input  logic        i_IOT,
    input  logic [5:0]  i_Device,
    input  logic [2:0]  i_Op,
    input  logic [11:0] i_AC,
    output logic        o_Done,
    output logic        o_Skip,
    output logic        o_ClearAC,
    output logic [11:0] o_ACData,
    output logic        o_IRQ,
    output logic        o_Overrun
);
    kbd_state_e  state_q;
    logic [7:0]  kbuf_q;
    logic        flag_q;
    logic        done_q, skip_q, clr_q, ovr_q;
    logic [11:0] acd_q;

    logic        fifo_full, fifo_empty, pop;
    logic [7:0]  fifo_head;
    logic        iot_hit, kie_op;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (i_Clock),
        .rst_i     (i_Reset),
        .wr_en_i   (i_RX_DV),
        .wr_data_i (i_RX_Byte),
        .rd_en_i   (pop),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count_unused)
    );

    assign iot_hit = i_IOT && (i_Device == DEV_CODE);
    // A qualified IOT in IDLE wins over refill; refill resumes after RESP.
    assign pop     = (state_q == ST_IDLE) && !iot_hit && !flag_q && !fifo_empty;

`ifdef KBD_INT_EN
    logic int_en_q;
    assign kie_op = (i_Op == OP_KIE);
    assign o_IRQ  = flag_q & int_en_q;
    always_ff @(posedge i_Clock) begin
        if (i_Reset)                                   int_en_q <= 1'b1;
        else if (state_q == ST_IDLE && iot_hit && kie_op) int_en_q <= i_AC[0];
    end
`else
    logic ac_unused;
    assign ac_unused = ^i_AC;
    assign kie_op    = 1'b0;
    assign o_IRQ     = flag_q;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            kbuf_q  <= '0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
            skip_q  <= 1'b0;
            clr_q   <= 1'b0;
            acd_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            skip_q <= 1'b0;
            clr_q  <= 1'b0;
            acd_q  <= '0;
            if (i_RX_DV && fifo_full && !pop) ovr_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (iot_hit) begin
                        state_q <= ST_RESP;
                        done_q  <= 1'b1;
                        if (!kie_op) begin
                            skip_q <= i_Op[OP_SKIP_BIT] & flag_q;
                            clr_q  <= i_Op[OP_CLEAR_BIT];
                            acd_q  <= i_Op[OP_READ_BIT] ? {4'b0, kbuf_q} : '0;
                            if (i_Op == OP_KCF || i_Op[OP_CLEAR_BIT]) flag_q <= 1'b0;
                        end
                    end else if (pop) begin
                        state_q <= ST_LOAD;
                        kbuf_q  <= fifo_head;
                        flag_q  <= 1'b1;
                    end
                end
                ST_LOAD: state_q <= ST_IDLE;
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_Done    = done_q;
    assign o_Skip    = skip_q;
    assign o_ClearAC = clr_q;
    assign o_ACData  = acd_q;
    assign o_Overrun = ovr_q;

endmodule

// File: tb/tb_kbd_rx_ctrl.sv
// Self-checking bench for kbd_rx_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_kbd_rx_ctrl;
    localparam logic [5:0]  DEV   = 6'o03;
    localparam int unsigned DEPTH = 4;

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_RX_DV = 1'b0;
    logic [7:0]  i_RX_Byte = '0;
    logic        i_IOT = 1'b0;
    logic [5:0]  i_Device = '0;
    logic [2:0]  i_Op = '0;
    logic [11:0] i_AC = '0;
    logic        o_Done, o_Skip, o_ClearAC, o_IRQ, o_Overrun;
    logic [11:0] o_ACData;

    always #5 i_Clock = ~i_Clock;

    kbd_rx_ctrl #(.DEV_CODE(DEV), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
        .i_IOT(i_IOT), .i_Device(i_Device), .i_Op(i_Op), .i_AC(i_AC),
        .o_Done(o_Done), .o_Skip(o_Skip), .o_ClearAC(o_ClearAC), .o_ACData(o_ACData),
        .o_IRQ(o_IRQ), .o_Overrun(o_Overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, keyboard buffer and flag.
    logic [7:0]  mq[$];
    logic [7:0]  m_buf;
    logic        m_flag, m_ovr, m_busy, m_ie;
    logic        e_done, e_skip, e_clr;
    logic [11:0] e_ac;

    task automatic model_step(input logic rst, input logic dv, input logic [7:0] b,
                              input logic iot, input logic [5:0] dev,
                              input logic [2:0] op, input logic [11:0] ac);
        logic hit, take;
        if (rst) begin
            mq.delete();
            m_buf = '0; m_flag = 0; m_ovr = 0; m_busy = 0; m_ie = 1;
            e_done = 0; e_skip = 0; e_clr = 0; e_ac = '0;
            return;
        end
        hit  = iot && dev == DEV && !m_busy;
        take = !m_busy && !hit && !m_flag && mq.size() > 0;
        e_done = hit; e_skip = 0; e_clr = 0; e_ac = '0;
        if (hit) begin
`ifdef KBD_INT_EN
            if (op == 3'd5) m_ie = ac[0];
            else begin
`endif
                e_skip = op[0] & m_flag;
                e_clr  = op[1];
                e_ac   = op[2] ? {4'b0, m_buf} : 12'h0;
                if (op == 3'd0 || op[1]) m_flag = 0;
`ifdef KBD_INT_EN
            end
`endif
        end
        if (take) begin
            m_buf  = mq.pop_front();
            m_flag = 1;
        end
        if (dv) begin
            if (mq.size() < DEPTH) mq.push_back(b);
            else m_ovr = 1;
        end
        m_busy = hit || take;
    endtask

    task automatic compare_all();
        check_eq("done", o_Done, e_done);
        check_eq("skip", o_Skip, e_skip);
        check_eq("clrac", o_ClearAC, e_clr);
        check_eq("acdata", o_ACData, e_ac);
`ifdef KBD_INT_EN
        check_eq("irq", o_IRQ, m_flag & m_ie);
`else
        check_eq("irq", o_IRQ, m_flag);
`endif
        check_eq("overrun", o_Overrun, m_ovr);
    endtask

    task automatic step(input logic rst, input logic dv, input logic [7:0] b,
                        input logic iot, input logic [5:0] dev,
                        input logic [2:0] op, input logic [11:0] ac);
        i_Reset = rst; i_RX_DV = dv; i_RX_Byte = b;
        i_IOT = iot; i_Device = dev; i_Op = op; i_AC = ac;
        @(posedge i_Clock);
        model_step(rst, dv, b, iot, dev, op, ac);
        @(negedge i_Clock);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 6'o0, 3'd0, 12'h0);
    endtask
    task automatic push(input logic [7:0] b);
        step(0, 1, b, 0, 6'o0, 3'd0, 12'h0);
    endtask
    task automatic iot(input logic [2:0] op, input logic [5:0] dev, input logic [11:0] ac);
        step(0, 0, 8'h00, 1, dev, op, ac);
    endtask
    task automatic do_reset();
        step(1, 0, 8'h00, 0, 6'o0, 3'd0, 12'h0);
        step(1, 0, 8'h00, 0, 6'o0, 3'd0, 12'h0);
    endtask

    logic [7:0] exp_bytes [6];
    int gap;

    initial begin
        @(negedge i_Clock);
        do_reset();
        check_eq("rst_irq", o_IRQ, 0);
        check_eq("rst_ovr", o_Overrun, 0);

        // Single byte, KSF then KRB.
        push(8'h41); idle(2);
        check_eq("t1_flag", o_IRQ, 1);
        iot(3'd1, DEV, 12'h0);
        check_eq("t1_ksf_done", o_Done, 1);
        check_eq("t1_ksf_skip", o_Skip, 1);
        idle(2);
        iot(3'd6, DEV, 12'h0);
        check_eq("t1_krb_clr", o_ClearAC, 1);
        check_eq("t1_krb_ac", o_ACData, 12'h041);
        check_eq("t1_flag_clr", o_IRQ, 0);
        idle(2);

        // Three bytes drained in order.
        push(8'h31); push(8'h32); push(8'h33); idle(2);
        for (int i = 0; i < 3; i++) begin
            iot(3'd6, DEV, 12'h0);
            check_eq("t2_krb_ac", o_ACData, 12'h031 + 12'(i));
            idle(3);
        end
        iot(3'd1, DEV, 12'h0);
        check_eq("t2_ksf_empty", o_Skip, 0);
        idle(2);

        // Overflow: six bytes, five survive.
        for (int i = 0; i < 6; i++) begin
            exp_bytes[i] = 8'hA0 + 8'(i);
            push(exp_bytes[i]);
        end
        check_eq("t3_overrun", o_Overrun, 1);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            iot(3'd6, DEV, 12'h0);
            check_eq("t3_order", o_ACData, {4'b0, exp_bytes[i]});
            idle(3);
        end
        check_eq("t3_lost", o_IRQ, 0);

        // Wrong device, then KCF, then reload.
        do_reset();
        push(8'h51); push(8'h52); idle(3);
        iot(3'd6, 6'o04, 12'h0);
        check_eq("t4_nodev_done", o_Done, 0);
        check_eq("t4_nodev_flag", o_IRQ, 1);
        idle(2);
        iot(3'd0, DEV, 12'h0);
        check_eq("t4_kcf_done", o_Done, 1);
        check_eq("t4_kcf_ac", o_ACData, 12'h000);
        check_eq("t4_kcf_clr", o_ClearAC, 0);
        check_eq("t4_kcf_flag", o_IRQ, 0);
        idle(3);
        iot(3'd6, DEV, 12'h0);
        check_eq("t4_reload", o_ACData, 12'h052);
        idle(3);

        // Push coincident with a pop from a full FIFO.
        do_reset();
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        idle(2);
        iot(3'd2, DEV, 12'h0);
        idle(1);
        push(8'h99);
        check_eq("t5_no_ovr", o_Overrun, 0);
        push(8'hAA);
        check_eq("t5_full_again", o_Overrun, 1);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            iot(3'd6, DEV, 12'h0);
            check_eq("t5_drain", o_ACData, (i == 4) ? 12'h099 : 12'h061 + 12'(i));
            idle(3);
        end

`ifdef KBD_INT_EN
        do_reset();
        push(8'h77); idle(3);
        iot(3'd5, DEV, 12'h000);
        check_eq("t6_kie_done", o_Done, 1);
        idle(1);
        check_eq("t6_irq_off", o_IRQ, 0);
        iot(3'd5, DEV, 12'h001);
        idle(1);
        check_eq("t6_irq_on", o_IRQ, 1);
`endif
        // Reset coincident with an IOT strobe drops the response.
        push(8'h12); idle(3);
        step(1, 0, 8'h00, 1, DEV, 3'd6, 12'h0);
        check_eq("t6_rst_done", o_Done, 0);
        check_eq("t6_rst_ac", o_ACData, 12'h000);
        step(0, 0, 8'h00, 0, 6'o0, 3'd0, 12'h0);
        check_eq("t6_rst_after", o_Done, 0);

        // Randomized traffic.
        gap = 3;
        for (int c = 0; c < 4000; c++) begin
            logic dv, io, rs;
            logic [5:0] dv_code;
            rs = ($urandom_range(599) == 0);
            dv = ($urandom_range(2) == 0);
            io = (gap >= 2) && ($urandom_range(3) == 0);
            dv_code = ($urandom_range(3) == 0) ? 6'($urandom_range(63)) : DEV;
            step(rs, dv, 8'($urandom), io, dv_code, 3'($urandom_range(7)), 12'($urandom));
            gap = io ? 0 : gap + 1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
